demux32_4_buf: RTL and testbench
================================

DEMUX32_4_BUF -- requirements
Module: demux32_4_buf

Interface
REQ-001 Parameter WIDTH, default 32, is the data width of din and each output data port.
REQ-002 Parameter DEPTH, default 2, is the number of buffered entries; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  is the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that the producer offers din/Ctrl.
REQ-006 in_ready  output  1  SHALL indicate that the block can accept an entry.
REQ-007 Ctrl  input  2  SHALL select the destination channel 0..3 for the offered entry.
REQ-008 din  input  WIDTH  is the offered data word.
REQ-009 o0, o1, o2, o3  output  WIDTH each  are the per-channel data ports.
REQ-010 v0, v1, v2, v3  output  1 each  are the per-channel valid flags.
REQ-011 r0, r1, r2, r3  input  1 each  are the per-channel ready flags from the consumers.
REQ-012 count  output  clog2(DEPTH)+1  SHALL report the number of occupied entries.

Function
REQ-013 Storage SHALL be a FIFO of DEPTH entries, each holding {Ctrl, din}, with wrapping read and write pointers.
REQ-014 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; it stores {Ctrl, din} at the write pointer.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend on r0..r3, so there is no same-cycle pass-through when the FIFO is full.
REQ-016 When count > 0, the head entry's channel c SHALL drive vc=1 and oc=head data; all other v SHALL be 0 and all other o SHALL be 0.
REQ-017 When count = 0, v0..v3 SHALL be 0 and o0..o3 SHALL be 0.
REQ-018 A pop SHALL occur on a rising edge where count > 0 and the ready flag of the head entry's channel is 1; ready flags of non-head channels SHALL be ignored.
REQ-019 Latency SHALL be one cycle: an entry pushed at edge N into an empty FIFO appears on its channel after edge N.
REQ-020 Delivery order SHALL be strictly FIFO across all channels, so the head entry blocks later entries to other channels (no reordering).
REQ-021 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 A push with no pop SHALL increment count; a pop with no push SHALL decrement count.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Once asserted, head data and the head channel SHALL remain stable until that entry is popped.
REQ-025 A push when full SHALL be impossible by construction; in_valid while in_ready=0 SHALL have no effect.
REQ-026 Outputs SHALL be a function of registered state only (no combinational path from in_valid/din/Ctrl to o/v).

Reset
REQ-027 While rst=1, the block SHALL immediately, independent of clk, set count=0, both pointers=0, v0..v3=0, o0..o3=0 and in_ready=0.
REQ-028 After rst deasserts, in_ready SHALL be 1 without waiting for a clock edge, since count=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; FIFO storage contents need not be cleared.

Verification
REQ-030 Single push: push Ctrl=2, din=0xDEADBEEF with r2=1 -> v2=1 and o2=0xDEADBEEF for one cycle after the push edge, v0/v1/v3=0, then count returns to 0.
REQ-031 Backpressure fill: r0..r3=0, push 0x11 to channel 1 and 0x22 to channel 3 -> count=2 and in_ready=0; a third in_valid is ignored; v1=1 with o1=0x11.
REQ-032 Head-of-line order: FIFO holds {ch1:0x11, ch3:0x22}, r3=1 and r1=0 -> nothing pops; then r1=1 -> 0x11 is delivered, after which v3=1 with o3=0x22.
REQ-033 Simultaneous push and pop: count=1 with head ch0=0xA, r0=1, and push ch0=0xB in the same cycle -> count stays 1 and o0=0xB on the next cycle.
REQ-034 Wrap-around: 5 sequential entries 1..5 to channel (i mod 4) with all ready=1 -> every value arrives in order on the correct channel and the pointers wrap without loss.
REQ-035 Async reset mid-operation: count=2, assert rst between clock edges -> v0..v3=0 and count=0 immediately; after release, in_ready=1 and no stale data is delivered.

Source files
------------

// File: rtl/demux32_4_buf.sv
// demux32_4_buf: buffered 1-to-4 demultiplexer.
// Each accepted word is stored together with its destination channel in a
// small FIFO. The head entry is presented on exactly one channel and is
// released only by that channel's ready flag, so delivery stays in strict
// arrival order across all four channels.
module demux32_4_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               Ctrl,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         o0,
    output logic [WIDTH-1:0]         o1,
    output logic [WIDTH-1:0]         o2,
    output logic [WIDTH-1:0]         o3,
    output logic                     v0,
    output logic                     v1,
    output logic                     v2,
    output logic                     v3,
    input  logic                     r0,
    input  logic                     r1,
    input  logic                     r2,
    input  logic                     r3,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH+1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_empty;
    logic             w_full;
    logic [WIDTH+1:0] w_head;
    logic [1:0]       w_head_ch;
    logic [WIDTH-1:0] w_head_data;
    logic             w_head_ready;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_ch   = w_head[WIDTH+1:WIDTH];
    assign w_head_data = w_head[WIDTH-1:0];

    // rst is folded in so the producer sees "not ready" for the whole reset
    // window, not just after the count register has been cleared.
    assign in_ready = ~rst & ~w_full;
    assign count    = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = ~w_empty & w_head_ready;

    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    // Only the head entry's channel can release it; other ready flags are ignored.
    always_comb begin
        w_head_ready = 1'b0;
        case (w_head_ch)
            2'd0:    w_head_ready = r0;
            2'd1:    w_head_ready = r1;
            2'd2:    w_head_ready = r2;
            default: w_head_ready = r3;
        endcase
    end

    // Storage array; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {Ctrl, din};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Route the head entry to its channel; outputs depend only on registered state.
    always_comb begin
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        v3 = 1'b0;
        o0 = '0;
        o1 = '0;
        o2 = '0;
        o3 = '0;
        if (!w_empty) begin
            case (w_head_ch)
                2'd0: begin
                    v0 = 1'b1;
                    o0 = w_head_data;
                end
                2'd1: begin
                    v1 = 1'b1;
                    o1 = w_head_data;
                end
                2'd2: begin
                    v2 = 1'b1;
                    o2 = w_head_data;
                end
                default: begin
                    v3 = 1'b1;
                    o3 = w_head_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux32_4_buf.sv
// Testbench for demux32_4_buf: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_demux32_4_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ctrl;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  o0, o1, o2, o3;
    logic              v0, v1, v2, v3;
    logic [3:0]        r_vec;
    logic [$clog2(DEPTH):0] count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the FIFO as two parallel queues (channel, data).
    int               q_ch[$];
    logic [WIDTH-1:0] q_d[$];

    demux32_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Ctrl     (ctrl),
        .din      (din),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .v0       (v0),
        .v1       (v1),
        .v2       (v2),
        .v3       (v3),
        .r0       (r_vec[0]),
        .r1       (r_vec[1]),
        .r2       (r_vec[2]),
        .r3       (r_vec[3]),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] o_of(input int c);
        case (c)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            default: return o3;
        endcase
    endfunction

    function automatic logic v_of(input int c);
        case (c)
            0:       return v0;
            1:       return v1;
            2:       return v2;
            default: return v3;
        endcase
    endfunction

    task automatic check_model(input string where);
        logic             ev;
        logic [WIDTH-1:0] eo;
        chk({where, ".count"}, 64'(count), 64'(q_ch.size()));
        chk({where, ".in_ready"}, 64'(in_ready), 64'(q_ch.size() < DEPTH));
        for (int c = 0; c < 4; c++) begin
            ev = (q_ch.size() > 0) && (q_ch[0] == c);
            eo = ev ? q_d[0] : '0;
            chk($sformatf("%s.v%0d", where, c), 64'(v_of(c)), 64'(ev));
            chk($sformatf("%s.o%0d", where, c), 64'(o_of(c)), 64'(eo));
        end
    endtask

    // One clock: decide model push/pop from pre-edge state, clock, then compare.
    task automatic cycle(input string where);
        bit do_pop;
        bit do_push;
        do_pop  = (q_ch.size() > 0) && r_vec[q_ch[0]];
        do_push = in_valid && (q_ch.size() < DEPTH);
        @(posedge clk);
        if (do_pop) begin
            void'(q_ch.pop_front());
            void'(q_d.pop_front());
        end
        if (do_push) begin
            q_ch.push_back(int'(ctrl));
            q_d.push_back(din);
        end
        #1;
        check_model(where);
    endtask

    task automatic drive(input logic v, input int ch, input logic [WIDTH-1:0] d);
        in_valid = v;
        ctrl     = 2'(ch);
        din      = d;
    endtask

    initial begin
        rst   = 1'b1;
        r_vec = 4'b0000;
        drive(1'b0, 0, '0);

        // Reset state, before any clock edge
        #1;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.v", 64'({v3, v2, v1, v0}), 64'd0);
        #11;
        rst = 1'b0;
        #1;
        chk("rel.in_ready", 64'(in_ready), 64'd1);
        check_model("rel");

        // Single push to channel 2, consumed immediately
        r_vec = 4'b0100;
        drive(1'b1, 2, 32'hDEADBEEF);
        cycle("single.push");
        chk("single.v2", 64'(v2), 64'd1);
        chk("single.o2", 64'(o2), 64'hDEADBEEF);
        drive(1'b0, 0, '0);
        cycle("single.pop");
        chk("single.count_after", 64'(count), 64'd0);

        // Backpressure fill; third offer must be ignored
        r_vec = 4'b0000;
        drive(1'b1, 1, 32'h11);
        cycle("fill.a");
        drive(1'b1, 3, 32'h22);
        cycle("fill.b");
        chk("fill.count", 64'(count), 64'd2);
        chk("fill.in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 0, 32'h33);
        cycle("fill.ignored");
        chk("fill.v1", 64'(v1), 64'd1);
        chk("fill.o1", 64'(o1), 64'h11);
        drive(1'b0, 0, '0);

        // Head-of-line: ready on ch3 alone must not pop the ch1 head
        r_vec = 4'b1000;
        cycle("hol.blocked0");
        cycle("hol.blocked1");
        chk("hol.count_blocked", 64'(count), 64'd2);
        r_vec = 4'b0010;
        cycle("hol.release");
        chk("hol.v3", 64'(v3), 64'd1);
        chk("hol.o3", 64'(o3), 64'h22);
        chk("hol.v1", 64'(v1), 64'd0);
        r_vec = 4'b1000;
        cycle("hol.drain");

        // Simultaneous push and pop
        r_vec = 4'b0000;
        drive(1'b1, 0, 32'hA);
        cycle("simul.setup");
        r_vec = 4'b0001;
        drive(1'b1, 0, 32'hB);
        cycle("simul.both");
        chk("simul.count", 64'(count), 64'd1);
        chk("simul.o0", 64'(o0), 64'hB);
        drive(1'b0, 0, '0);
        cycle("simul.drain");

        // Wrap-around with all consumers ready
        r_vec = 4'b1111;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, i % 4, WIDTH'(i));
            cycle($sformatf("wrap.%0d", i));
            chk($sformatf("wrap.v%0d", i), 64'(v_of(i % 4)), 64'd1);
            chk($sformatf("wrap.o%0d", i), 64'(o_of(i % 4)), 64'(i));
        end
        drive(1'b0, 0, '0);
        cycle("wrap.drain");

        // Async reset between clock edges while holding two entries
        r_vec = 4'b0000;
        drive(1'b1, 0, 32'h55);
        cycle("arst.a");
        drive(1'b1, 2, 32'h66);
        cycle("arst.b");
        drive(1'b0, 0, '0);
        chk("arst.pre_count", 64'(count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.v", 64'({v3, v2, v1, v0}), 64'd0);
        chk("arst.o0", 64'(o0), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd0);
        q_ch.delete();
        q_d.delete();
        #3;
        rst = 1'b0;
        #1;
        chk("arst.rel_in_ready", 64'(in_ready), 64'd1);
        r_vec = 4'b1111;
        cycle("arst.nostale0");
        cycle("arst.nostale1");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), WIDTH'($urandom));
            r_vec = 4'($urandom);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
